jalr_btb: RTL and testbench

Fully-associative branch target buffer for indirect jumps (JALR, excluding returns) in the frontend. It consumes the `bp_resolve_t` resolution stream that the execute stage's branch resolution logic drives. It learns `pc -> target` pairs from resolved JumpR mispredicts and answers frontend lookups one cycle later with a predicted target.

---
 rtl/jalr_btb_pkg.sv | 35 +++
 rtl/jalr_btb.sv | 107 ++++++++++
 tb/tb_jalr_btb.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/jalr_btb_pkg.sv
// Shared frontend types: VLEN, the branch resolution stream and the JALR BTB entry.
// JALR_BTB_CONF_EN adds a 2-bit confidence counter to each BTB entry.
package riscv;
  localparam int unsigned VLEN = 32;
endpackage

package ariane_pkg;
  typedef enum logic [2:0] {
    NoCF,
    Branch,
    Jump,
    JumpR,
    Return
  } cf_t;

  typedef struct packed {
    logic                   valid;
    logic [riscv::VLEN-1:0] pc;
    logic [riscv::VLEN-1:0] target_address;
    logic                   is_mispredict;
    logic                   is_taken;
    cf_t                    cf_type;
  } bp_resolve_t;

  localparam int unsigned JALR_BTB_TAG_W = riscv::VLEN - 1;

  typedef struct packed {
    logic                      valid;
    logic [JALR_BTB_TAG_W-1:0] tag;
    logic [riscv::VLEN-1:0]    target;
`ifdef JALR_BTB_CONF_EN
    logic [1:0]                conf;
`endif
  } jalr_btb_entry_t;
endpackage

// File: rtl/jalr_btb.sv
// Fully-associative BTB for indirect jumps; learns from JumpR mispredicts, predicts one cycle after lookup.
// JALR_BTB_CONF_EN: 2-bit confidence counter gates target replacement on mispredict hits.
module jalr_btb
  import ariane_pkg::*;
#(
  parameter int unsigned NR_ENTRIES = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   flush_i,
  input  logic                   debug_mode_i,
  input  bp_resolve_t            resolved_branch_i,
  input  logic                   lookup_valid_i,
  input  logic [riscv::VLEN-1:0] lookup_pc_i,
  output logic                   predict_valid_o,
  output logic                   predict_hit_o,
  output logic [riscv::VLEN-1:0] predict_address_o
);
  localparam int unsigned PTR_W = $clog2(NR_ENTRIES);

  jalr_btb_entry_t           entries_q [NR_ENTRIES];
  jalr_btb_entry_t           entries_d [NR_ENTRIES];
  logic [PTR_W-1:0]          rr_q, rr_d;
  logic [JALR_BTB_TAG_W-1:0] upd_tag, lkp_tag;
  logic [NR_ENTRIES-1:0]     upd_match, lkp_match;
  logic [PTR_W-1:0]          upd_idx;
  logic                      upd_hit, upd_en, lkp_fire;
  logic [riscv::VLEN-1:0]    lkp_target;
  logic                      unused_bits;

  assign upd_tag     = resolved_branch_i.pc[riscv::VLEN-1:1];
  assign lkp_tag     = lookup_pc_i[riscv::VLEN-1:1];
  assign unused_bits = ^{resolved_branch_i.is_taken, resolved_branch_i.pc[0], lookup_pc_i[0]};

  assign upd_en = resolved_branch_i.valid && (resolved_branch_i.cf_type == JumpR)
                  && !debug_mode_i && !flush_i;
  assign lkp_fire = lookup_valid_i && !flush_i;

  // Tags are unique, so at most one entry matches and OR-reducing targets selects it.
  always_comb begin
    upd_match  = '0;
    lkp_match  = '0;
    upd_idx    = '0;
    lkp_target = '0;
    for (int unsigned i = 0; i < NR_ENTRIES; i++) begin
      upd_match[i] = entries_q[i].valid && (entries_q[i].tag == upd_tag);
      lkp_match[i] = entries_q[i].valid && (entries_q[i].tag == lkp_tag);
      if (upd_match[i]) upd_idx = PTR_W'(i);
      if (lkp_match[i]) lkp_target = lkp_target | entries_q[i].target;
    end
  end

  assign upd_hit = |upd_match;

  always_comb begin
    entries_d = entries_q;
    rr_d      = rr_q;
    if (flush_i) begin
      for (int unsigned i = 0; i < NR_ENTRIES; i++) entries_d[i].valid = 1'b0;
      rr_d = '0;
    end else if (upd_en) begin
      if (resolved_branch_i.is_mispredict) begin
        if (upd_hit) begin
`ifdef JALR_BTB_CONF_EN
          if (entries_q[upd_idx].conf <= 2'd1) begin
            entries_d[upd_idx].target = resolved_branch_i.target_address;
            entries_d[upd_idx].conf   = 2'd1;
          end else begin
            entries_d[upd_idx].conf = entries_q[upd_idx].conf - 2'd1;
          end
`else
          entries_d[upd_idx].target = resolved_branch_i.target_address;
`endif
        end else begin
          entries_d[rr_q].valid  = 1'b1;
          entries_d[rr_q].tag    = upd_tag;
          entries_d[rr_q].target = resolved_branch_i.target_address;
`ifdef JALR_BTB_CONF_EN
          entries_d[rr_q].conf   = 2'd1;
`endif
          rr_d = rr_q + 1'b1;
        end
      end
`ifdef JALR_BTB_CONF_EN
      else if (upd_hit && (entries_q[upd_idx].conf != 2'd3)) begin
        entries_d[upd_idx].conf = entries_q[upd_idx].conf + 2'd1;
      end
`endif
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < NR_ENTRIES; i++) entries_q[i] <= '0;
      rr_q              <= '0;
      predict_valid_o   <= 1'b0;
      predict_hit_o     <= 1'b0;
      predict_address_o <= '0;
    end else begin
      entries_q         <= entries_d;
      rr_q              <= rr_d;
      predict_valid_o   <= lkp_fire;
      predict_hit_o     <= lkp_fire && (|lkp_match);
      predict_address_o <= lkp_fire ? lkp_target : '0;
    end
  end
endmodule

// File: tb/tb_jalr_btb.sv
// Randomized and directed bench for jalr_btb against a table-based reference model.
// Build with JALR_BTB_CONF_EN defined to exercise the confidence policy.
`timescale 1ns/1ps
module tb_jalr_btb;
  import ariane_pkg::*;

  localparam int unsigned NR = 8;
  localparam int unsigned VL = riscv::VLEN;
`ifdef JALR_BTB_CONF_EN
  localparam bit CONF = 1'b1;
`else
  localparam bit CONF = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          flush = 1'b0;
  logic          dbg = 1'b0;
  logic          lv = 1'b0;
  bp_resolve_t   rb = '0;
  logic [VL-1:0] lpc = '0;
  logic          pv, ph;
  logic [VL-1:0] pa;

  jalr_btb #(.NR_ENTRIES(NR)) dut (
    .clk_i             (clk),
    .rst_i             (rst),
    .flush_i           (flush),
    .debug_mode_i      (dbg),
    .resolved_branch_i (rb),
    .lookup_valid_i    (lv),
    .lookup_pc_i       (lpc),
    .predict_valid_o   (pv),
    .predict_hit_o     (ph),
    .predict_address_o (pa)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: plain table of (pc, target, conf) plus a round-robin slot number.
  bit            m_valid [NR];
  logic [VL-1:0] m_pc    [NR];
  logic [VL-1:0] m_tgt   [NR];
  int            m_conf  [NR];
  int            m_rr;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int m_find(input logic [VL-1:0] pc);
    for (int i = 0; i < NR; i++)
      if (m_valid[i] && ((m_pc[i] >> 1) == (pc >> 1))) return i;
    return -1;
  endfunction

  function automatic void m_reset();
    for (int i = 0; i < NR; i++) begin
      m_valid[i] = 1'b0; m_pc[i] = '0; m_tgt[i] = '0; m_conf[i] = 0;
    end
    m_rr = 0;
  endfunction

  function automatic void m_update(input bit v, input cf_t cf, input bit mis,
                                   input logic [VL-1:0] pc, input logic [VL-1:0] tgt,
                                   input bit d, input bit f);
    int idx;
    if (f) begin
      for (int i = 0; i < NR; i++) m_valid[i] = 1'b0;
      m_rr = 0;
      return;
    end
    if (!v || cf != JumpR || d) return;
    idx = m_find(pc);
    if (mis) begin
      if (idx < 0) begin
        m_valid[m_rr] = 1'b1; m_pc[m_rr] = pc; m_tgt[m_rr] = tgt; m_conf[m_rr] = 1;
        m_rr = (m_rr + 1) % NR;
      end else if (!CONF || m_conf[idx] <= 1) begin
        m_tgt[idx] = tgt; m_conf[idx] = 1;
      end else begin
        m_conf[idx] = m_conf[idx] - 1;
      end
    end else if (idx >= 0 && CONF) begin
      m_conf[idx] = (m_conf[idx] >= 3) ? 3 : m_conf[idx] + 1;
    end
  endfunction

  task automatic step(input bit v, input cf_t cf, input bit mis, input logic [VL-1:0] pc,
                      input logic [VL-1:0] tgt, input bit d, input bit f, input bit l,
                      input logic [VL-1:0] lp);
    int idx;
    bit ev, eh;
    logic [VL-1:0] ea;
    rb = '0;
    rb.valid = v; rb.cf_type = cf; rb.is_mispredict = mis;
    rb.pc = pc; rb.target_address = tgt; rb.is_taken = 1'b1;
    dbg = d; flush = f; lv = l; lpc = lp;
    ev = l && !f;
    idx = m_find(lp);
    eh = ev && (idx >= 0);
    ea = '0;
    if (eh) ea = m_tgt[idx];
    @(posedge clk); #1;
    m_update(v, cf, mis, pc, tgt, d, f);
    check("pred_valid", 64'(pv), 64'(ev));
    check("pred_hit", 64'(ph), 64'(eh));
    check("pred_addr", 64'(pa), 64'(ea));
  endtask

  task automatic upd(input logic [VL-1:0] pc, input logic [VL-1:0] tgt, input bit mis);
    step(1'b1, JumpR, mis, pc, tgt, 1'b0, 1'b0, 1'b0, '0);
  endtask

  task automatic look(input logic [VL-1:0] pc);
    step(1'b0, NoCF, 1'b0, '0, '0, 1'b0, 1'b0, 1'b1, pc);
  endtask

  task automatic do_reset();
    rst = 1'b1; rb = '0; flush = 1'b0; dbg = 1'b0; lv = 1'b0; lpc = '0;
    #3;
    check("rst_valid", 64'(pv), 64'd0);
    check("rst_hit", 64'(ph), 64'd0);
    check("rst_addr", 64'(pa), 64'd0);
    m_reset();
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    logic [VL-1:0] pc, lp, tgt, t6_exp;
    cf_t cf;
    #1;
    do_reset();

    // 1: empty BTB lookup
    look(32'h8000_0000);
    check("t1_valid", 64'(pv), 64'd1);
    check("t1_hit", 64'(ph), 64'd0);

    // 2: same-cycle lookup misses, next cycle hits
    step(1'b1, JumpR, 1'b1, 32'h8000_0010, 32'h8000_4000, 1'b0, 1'b0, 1'b1, 32'h8000_0010);
    check("t2_same_cycle_hit", 64'(ph), 64'd0);
    look(32'h8000_0010);
    check("t2_hit", 64'(ph), 64'd1);
    check("t2_addr", 64'(pa), 64'h8000_4000);

    // 3: fill NR+1 PCs, verify eviction of slot 0 and wrap to slot 1
    do_reset();
    for (int i = 0; i <= NR; i++) upd(32'h8001_0000 + 32'(i) * 4, 32'h4000_0000 + 32'(i) * 256, 1'b1);
    look(32'h8001_0000);
    check("t3_first_miss", 64'(ph), 64'd0);
    look(32'h8001_0000 + 32'(NR) * 4);
    check("t3_last_hit", 64'(ph), 64'd1);
    check("t3_last_addr", 64'(pa), 64'(32'h4000_0000 + 32'(NR) * 256));
    look(32'h8001_0004);
    check("t3_second_hit", 64'(ph), 64'd1);
    upd(32'h8002_0000, 32'h4100_0000, 1'b1);
    look(32'h8001_0004);
    check("t3_wrap_evict", 64'(ph), 64'd0);

    // 4: Return and debug-mode updates are ignored
    step(1'b1, Return, 1'b1, 32'h8000_0100, 32'h8000_5000, 1'b0, 1'b0, 1'b0, '0);
    look(32'h8000_0100);
    check("t4_return_miss", 64'(ph), 64'd0);
    step(1'b1, JumpR, 1'b1, 32'h8000_0104, 32'h8000_5004, 1'b1, 1'b0, 1'b0, '0);
    look(32'h8000_0104);
    check("t4_debug_miss", 64'(ph), 64'd0);

    // 5: flush with concurrent update and lookup
    upd(32'h8000_0200, 32'h8000_6000, 1'b1);
    step(1'b1, JumpR, 1'b1, 32'h8000_0204, 32'h8000_6004, 1'b0, 1'b1, 1'b1, 32'h8000_0200);
    check("t5_flush_valid", 64'(pv), 64'd0);
    look(32'h8000_0200);
    check("t5_stored_miss", 64'(ph), 64'd0);
    look(32'h8000_0204);
    check("t5_dropped_miss", 64'(ph), 64'd0);

    // 6: replacement policy
    do_reset();
    upd(32'h8000_0300, 32'h8000_7000, 1'b1);
    upd(32'h8000_0300, 32'h8000_7000, 1'b0);
    upd(32'h8000_0300, 32'h8000_7000, 1'b0);
    upd(32'h8000_0300, 32'h9000_0000, 1'b1);
    look(32'h8000_0300);
    t6_exp = CONF ? 32'h8000_7000 : 32'h9000_0000;
    check("t6_first_mis", 64'(pa), 64'(t6_exp));
    upd(32'h8000_0300, 32'h9000_0000, 1'b1);
    upd(32'h8000_0300, 32'h9000_0000, 1'b1);
    look(32'h8000_0300);
    check("t6_third_mis", 64'(pa), 64'h9000_0000);

    // Randomized traffic over a small PC pool so hits, evictions and aliasing on pc[0] occur
    do_reset();
    for (int n = 0; n < 800; n++) begin
      pc  = 32'h8000_1000 + 32'($urandom_range(0, 11)) * 8 + 32'($urandom_range(0, 1));
      lp  = 32'h8000_1000 + 32'($urandom_range(0, 11)) * 8 + 32'($urandom_range(0, 1));
      tgt = $urandom & 32'hFFFF_FFFE;
      if ($urandom_range(0, 9) < 6) cf = JumpR;
      else cf = cf_t'($urandom_range(0, 4));
      step($urandom_range(0, 4) != 0, cf, $urandom_range(0, 2) != 0, pc, tgt,
           $urandom_range(0, 19) == 0, $urandom_range(0, 49) == 0,
           $urandom_range(0, 3) != 0, lp);
    end

    // Asynchronous reset mid-operation drops entries and the pending response
    upd(32'h8000_0400, 32'h8000_8000, 1'b1);
    look(32'h8000_0400);
    check("mid_hit_before", 64'(ph), 64'd1);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_valid", 64'(pv), 64'd0);
    check("mid_rst_addr", 64'(pa), 64'd0);
    m_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    look(32'h8000_0400);
    check("mid_rst_miss", 64'(ph), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
